fpcvt_pipe: RTL and testbench
=============================

Name: fpcvt_pipe

Overview:
- Parametrised, pipelined successor to the team's 12-bit two's-complement to (sign, exponent, mantissa) converter.
- Converts DW-bit two's-complement samples to S/E/F floating form, with value = F * 2^E.
- Adds a valid/ready stream interface, 3-stage pipeline, selectable rounding mode, saturate/inexact flags and a saturation event counter.
- Sits between sample producers and the compressed-sample consumers.

Parameters:
- DW, 12, input width. Legal when DW-1-MW <= 2^EW-1.
- EW, 3, exponent width.
- MW, 4, mantissa width. Must satisfy MW >= 2.
- CNTW, 8, saturation counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_data  in  DW  two's-complement sample.
- rnd_mode  in  2  rounding mode, sampled with the input beat: 00 half-up, 01 truncate, 10 half-even, 11 treated as truncate.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_s  out  1  sign.
- out_e  out  EW  exponent.
- out_f  out  MW  mantissa.
- out_sat  out  1  result saturated.
- out_inexact  out  1  discarded bits were nonzero, or the result saturated.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNTW  count of accepted output beats with out_sat=1, saturating at all-ones.

Behaviour:
- Reset (async assert, sync use of the deasserted state):
  - all stage valids = 0; out_valid = 0; out_s/e/f/sat/inexact = 0; sat_count = 0.
  - in_ready = 1 once reset deasserts. Reset mid-stream discards all in-flight samples.
- Handshake:
  - A beat transfers when valid && ready on that side.
  - Global stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, no stage register changes and the out_* signals are held stable.
  - When not stalled, all stages advance; an empty stage propagates a bubble.
  - Latency is exactly 3 cycles from the input transfer to out_valid with no stall. Throughput is 1 sample/cycle. Order is preserved.
- Stage 1 (sign/magnitude):
  - s = in_data[DW-1]; mag = |in_data|.
  - Special case in_data = -2^(DW-1): mag clamps to 2^(DW-1)-1 and force_sat = 1.
  - rnd_mode is registered with the sample.
- Stage 2 (normalise):
  - p = index of the leading one of mag[DW-2:0].
  - If mag < 2^MW: E = 0, F = mag[MW-1:0], guard = 0, sticky = 0.
  - Otherwise: E = p-MW+1, F = mag[p:p-MW+1], guard = mag[p-MW], sticky = OR of mag[p-MW-1:0] (0 if that range is empty).
- Stage 3 (round):
  - Round-up condition per mode:
    - half-up: guard.
    - half-even: guard && (sticky || F[0]).
    - truncate: never.
  - On round-up with F not all-ones: F = F+1.
  - On round-up with F all-ones and E below its max: F = 1 followed by MW-1 zeros, E = E+1.
  - On round-up with F all-ones and E at max (all-ones): E and F = all-ones, sat = 1.
  - force_sat also sets E and F to all-ones with sat = 1.
  - inexact = guard || sticky || sat.
  - Zero input gives S=0, E=0, F=0, inexact=0.
- Counter:
  - sat_count increments on each output transfer with out_sat=1 and holds at all-ones.
  - sat_clr has priority over the increment in the same cycle and takes effect next cycle; the count reads 0 after the clear.

Test Plan (defaults DW=12, EW=3, MW=4):
1. 0x000 in each mode -> S0 E0 F0000, sat0, inexact0; 0x00F -> E0 F1111, exact.
2. 0x07D (125): half-up -> E4 F1000, inexact1; truncate -> E3 F1111, inexact1; half-even -> E4 F1000 (sticky=1).
3. Tie case: 0x02A (42): half-up -> E2 F1011; half-even -> E2 F1010; 0xFD6 (-42), half-even -> S1 E2 F1010.
4. Saturation:
   - 0x7FF half-up -> E7 F1111, sat1; 0x7FF truncate -> E7 F1111, sat0, inexact1.
   - 0x800 -> S1 E7 F1111, sat1.
   - Ten saturating beats with CNTW=3 -> sat_count = 7; sat_clr pulsed with a saturating beat in the same cycle -> sat_count = 0.
5. Streaming and backpressure:
   - 8 back-to-back beats with out_ready=1 -> first out_valid 3 cycles after the first accept, one result/cycle, in order.
   - Drop out_ready for 4 cycles mid-burst -> in_ready=0, out_* held stable, no loss or duplication after release.
6. Reset mid-burst: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately and all outputs 0. After release, a new beat appears after 3 cycles and no stale data emerges.

Source files
------------

// File: rtl/fpcvt_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fpcvt_pipe                                                 |
// | Description : Three-stage valid/ready pipeline that converts DW-bit      |
// |               two's-complement samples to sign / exponent / mantissa     |
// |               form (value = F * 2^E) with selectable rounding,           |
// |               saturate / inexact flags and a saturation event counter.   |
// | Ports       : clk, rst_n            clock, async active-low reset        |
// |               in_valid/in_ready     input handshake                      |
// |               in_data[DW]           two's-complement sample              |
// |               rnd_mode[2]           00 half-up, 01/11 truncate,          |
// |                                     10 half-even                         |
// |               out_valid/out_ready   output handshake                     |
// |               out_s/out_e/out_f     sign, exponent, mantissa             |
// |               out_sat/out_inexact   result flags                         |
// |               sat_clr               synchronous counter clear            |
// |               sat_count[CNTW]       saturating count of sat beats        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fpcvt_pipe #(
  parameter int DW   = 12,
  parameter int EW   = 3,
  parameter int MW   = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [1:0]      rnd_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_s,
  output logic [EW-1:0]   out_e,
  output logic [MW-1:0]   out_f,
  output logic            out_sat,
  output logic            out_inexact,
  input  logic            sat_clr,
  output logic [CNTW-1:0] sat_count
);

  localparam int PW = $clog2(DW);
  localparam logic [DW-1:0] c_most_neg    = {1'b1, {(DW-1){1'b0}}};
  // Bits below the guard position once the leading one sits at bit DW-2.
  localparam logic [DW-2:0] c_sticky_mask = (DW-1)'((1 << (DW-2-MW)) - 1);
  localparam logic [MW-1:0] c_f_carry     = {1'b1, {(MW-1){1'b0}}};

  // ---------------------------------------------------------------- control
  logic w_stall;
  assign w_stall  = out_valid && !out_ready;
  assign in_ready = !w_stall;

  // ---------------------------------------------------------------- stage 1
  logic          w_fsat;
  logic [DW-2:0] w_mag;

  // The most negative input has no positive counterpart; its magnitude is
  // clamped and the result is forced to saturate in stage 3.
  always_comb begin
    w_fsat = (in_data == c_most_neg);
    if (w_fsat)
      w_mag = '1;
    else if (in_data[DW-1])
      w_mag = ~in_data[DW-2:0] + (DW-1)'(1);
    else
      w_mag = in_data[DW-2:0];
  end

  logic          r_s1_valid;
  logic          r_s1_s;
  logic [DW-2:0] r_s1_mag;
  logic          r_s1_fsat;
  logic [1:0]    r_s1_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_mag   <= '0;
      r_s1_fsat  <= 1'b0;
      r_s1_rnd   <= 2'b00;
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_s    <= in_data[DW-1];
        r_s1_mag  <= w_mag;
        r_s1_fsat <= w_fsat;
        r_s1_rnd  <= rnd_mode;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [PW-1:0] w_lead;
  logic [DW-2:0] w_norm;
  logic [EW-1:0] w_e2;
  logic [MW-1:0] w_f2;
  logic          w_g2;
  logic          w_st2;

  // Left-justify the magnitude so the leading one lands at bit DW-2; the
  // mantissa, guard and sticky fields then sit at fixed positions.
  always_comb begin
    w_lead = '0;
    for (int i = 0; i < DW-1; i++) begin
      if (r_s1_mag[i])
        w_lead = PW'(i);
    end
    w_norm = r_s1_mag << (PW'(DW-2) - w_lead);
    if (~|r_s1_mag[DW-2:MW]) begin
      w_e2  = '0;
      w_f2  = r_s1_mag[MW-1:0];
      w_g2  = 1'b0;
      w_st2 = 1'b0;
    end else begin
      w_e2  = EW'({1'b0, w_lead} - (PW+1)'(MW-1));
      w_f2  = w_norm[DW-2 -: MW];
      w_g2  = w_norm[DW-2-MW];
      w_st2 = |(w_norm & c_sticky_mask);
    end
  end

  logic          r_s2_valid;
  logic          r_s2_s;
  logic [EW-1:0] r_s2_e;
  logic [MW-1:0] r_s2_f;
  logic          r_s2_g;
  logic          r_s2_st;
  logic          r_s2_fsat;
  logic [1:0]    r_s2_rnd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_s     <= 1'b0;
      r_s2_e     <= '0;
      r_s2_f     <= '0;
      r_s2_g     <= 1'b0;
      r_s2_st    <= 1'b0;
      r_s2_fsat  <= 1'b0;
      r_s2_rnd   <= 2'b00;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_s    <= r_s1_s;
        r_s2_e    <= w_e2;
        r_s2_f    <= w_f2;
        r_s2_g    <= w_g2;
        r_s2_st   <= w_st2;
        r_s2_fsat <= r_s1_fsat;
        r_s2_rnd  <= r_s1_rnd;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic          w_rup;
  logic [EW-1:0] w_e3;
  logic [MW-1:0] w_f3;
  logic          w_sat3;
  logic          w_inx3;

  always_comb begin
    case (r_s2_rnd)
      2'b00:   w_rup = r_s2_g;
      2'b10:   w_rup = r_s2_g && (r_s2_st || r_s2_f[0]);
      default: w_rup = 1'b0;
    endcase
    w_e3   = r_s2_e;
    w_f3   = r_s2_f;
    w_sat3 = 1'b0;
    if (r_s2_fsat) begin
      w_e3   = '1;
      w_f3   = '1;
      w_sat3 = 1'b1;
    end else if (w_rup) begin
      if (r_s2_f != '1) begin
        w_f3 = r_s2_f + MW'(1);
      end else if (r_s2_e != '1) begin
        // Mantissa overflow renormalises into the next exponent.
        w_f3 = c_f_carry;
        w_e3 = r_s2_e + EW'(1);
      end else begin
        w_e3   = '1;
        w_f3   = '1;
        w_sat3 = 1'b1;
      end
    end
    w_inx3 = r_s2_g || r_s2_st || w_sat3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_s       <= 1'b0;
      out_e       <= '0;
      out_f       <= '0;
      out_sat     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        out_s       <= r_s2_s;
        out_e       <= w_e3;
        out_f       <= w_f3;
        out_sat     <= w_sat3;
        out_inexact <= w_inx3;
      end
    end
  end

  // ---------------------------------------------------------------- counter
  logic [CNTW-1:0] r_sat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (sat_clr)
      r_sat_cnt <= '0;
    else if (out_valid && out_ready && out_sat && (r_sat_cnt != '1))
      r_sat_cnt <= r_sat_cnt + CNTW'(1);
  end

  assign sat_count = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fpcvt_pipe                                              |
// | Description : Directed self-checking bench for fpcvt_pipe (DW=12, EW=3,  |
// |               MW=4, CNTW=3). Expected results are hand-computed and      |
// |               queued at input acceptance; a negedge monitor pops them    |
// |               in order on every output transfer.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fpcvt_pipe;

  localparam int DW   = 12;
  localparam int EW   = 3;
  localparam int MW   = 4;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [1:0]      rnd_mode;
  logic            out_valid;
  logic            out_ready;
  logic            out_s;
  logic [EW-1:0]   out_e;
  logic [MW-1:0]   out_f;
  logic            out_sat;
  logic            out_inexact;
  logic            sat_clr;
  logic [CNTW-1:0] sat_count;

  always #5 clk = ~clk;

  fpcvt_pipe #(.DW(DW), .EW(EW), .MW(MW), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .rnd_mode    (rnd_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_e       (out_e),
    .out_f       (out_f),
    .out_sat     (out_sat),
    .out_inexact (out_inexact),
    .sat_clr     (sat_clr),
    .sat_count   (sat_count)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         n_out    = 0;
  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         acc_log[$];
  logic [9:0] w_obs;
  string      mon_tag;
  logic       prev_stall = 1'b0;
  logic [10:0] prev_out  = '0;
  int         first_out, last_out, seen_out, k, lat_wait, out_base;

  assign w_obs = {out_s, out_e, out_f, out_sat, out_inexact};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Packs {S, E, F, sat, inexact} in the same order as w_obs.
  function automatic logic [9:0] ex(input logic s, input int e, input int f,
                                    input logic sat, input logic inx);
    return {s, 3'(e), 4'(f), sat, inx};
  endfunction

  // Output monitor: results in order, hold-while-stalled, in_ready in stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {out_valid, w_obs}, prev_out);
      if (out_valid && !out_ready)
        check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", {1'b1, w_obs}, 0);
        end else begin
          mon_tag = tag_q.pop_front();
          check(mon_tag, w_obs, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, w_obs};
    end
  end

  // Starts and ends at posedge+1.
  task automatic send(input logic [11:0] d, input logic [1:0] m,
                      input logic [9:0] e, input string t);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    rnd_mode = m;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        tag_q.push_back(t);
        acc_log.push_back(cyc);
        break;
      end
      waited++;
      if (waited > 50) begin
        check({t, "_accept_timeout"}, 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string t);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({t, "_drain"}, exp_q.size(), 0);
  endtask

  // Waits for the first out_valid after the most recent acceptance.
  task automatic check_latency(input string t);
    lat_wait = 0;
    while (!out_valid && lat_wait < 10) begin
      @(negedge clk);
      lat_wait++;
    end
    check(t, cyc - acc_log[acc_log.size()-1], 3);
    @(posedge clk); #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    rnd_mode  = 2'b00;
    out_ready = 1'b1;
    sat_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", w_obs, 0);
    check("rst_sat_count", sat_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Zero / small values, first-beat latency.
    send(12'h000, 2'b00, ex(0,0,0,0,0), "zero_hu");
    check_latency("latency_first");
    send(12'h000, 2'b01, ex(0,0,0,0,0), "zero_tr");
    send(12'h000, 2'b10, ex(0,0,0,0,0), "zero_he");
    send(12'h000, 2'b11, ex(0,0,0,0,0), "zero_m3");
    send(12'h00F, 2'b00, ex(0,0,15,0,0), "x00f_exact");
    // Rounding with sticky.
    send(12'h07D, 2'b00, ex(0,4,8,0,1),  "x07d_hu");
    send(12'h07D, 2'b01, ex(0,3,15,0,1), "x07d_tr");
    send(12'h07D, 2'b10, ex(0,4,8,0,1),  "x07d_he");
    // Ties.
    send(12'h02A, 2'b00, ex(0,2,11,0,1), "x02a_hu");
    send(12'h02A, 2'b10, ex(0,2,10,0,1), "x02a_he");
    send(12'hFD6, 2'b10, ex(1,2,10,0,1), "xfd6_he");
    // Saturation.
    send(12'h7FF, 2'b00, ex(0,7,15,1,1), "x7ff_hu");
    send(12'h7FF, 2'b01, ex(0,7,15,0,1), "x7ff_tr");
    send(12'h800, 2'b00, ex(1,7,15,1,1), "x800_hu");
    drain("directed");
    check("cnt_after_directed", sat_count, 2);

    // Counter: clear, saturate at all-ones, clear beats a same-cycle increment.
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("cnt_clr", sat_count, 0);
    for (int i = 0; i < 10; i++)
      send(12'h800, 2'b00, ex(1,7,15,1,1), "cnt_sat_beat");
    drain("cnt_burst");
    check("cnt_hold_max", sat_count, 7);
    out_ready = 1'b0;
    send(12'h800, 2'b00, ex(1,7,15,1,1), "cnt_clr_beat");
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("cnt_beat_parked", out_valid, 1);
    sat_clr   = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    check("cnt_clr_priority", sat_count, 0);
    @(posedge clk); #1;
    check("cnt_after_clr", sat_count, 0);
    drain("cnt_clr");

    // Back-to-back streaming.
    acc_log.delete();
    out_base = n_out;
    first_out = -1; last_out = -1; seen_out = 0; k = 0;
    fork
      begin
        send(12'h000, 2'b00, ex(0,0,0,0,0),   "st0");
        send(12'h00F, 2'b00, ex(0,0,15,0,0),  "st1");
        send(12'h07D, 2'b00, ex(0,4,8,0,1),   "st2");
        send(12'h02A, 2'b00, ex(0,2,11,0,1),  "st3");
        send(12'hFD6, 2'b00, ex(1,2,11,0,1),  "st4");
        send(12'h7FF, 2'b00, ex(0,7,15,1,1),  "st5");
        send(12'h800, 2'b01, ex(1,7,15,1,1),  "st6");
        send(12'h010, 2'b00, ex(0,1,8,0,0),   "st7");
      end
      begin
        while (seen_out < 8 && k < 40) begin
          @(negedge clk);
          k++;
          if (out_valid && out_ready) begin
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            seen_out++;
          end
        end
      end
    join
    check("stream_latency", first_out - acc_log[0], 3);
    check("stream_rate", last_out - first_out, 7);
    check("stream_count", seen_out, 8);
    drain("stream");

    // Backpressure mid-burst.
    out_base = n_out;
    fork
      begin
        send(12'hFFF, 2'b00, ex(1,0,1,0,0),   "bp0");
        send(12'h123, 2'b00, ex(0,5,9,0,1),   "bp1");
        send(12'h123, 2'b01, ex(0,5,9,0,1),   "bp2");
        send(12'h026, 2'b10, ex(0,2,10,0,1),  "bp3");
        send(12'h03E, 2'b10, ex(0,3,8,0,1),   "bp4");
        send(12'h07D, 2'b11, ex(0,3,15,0,1),  "bp5");
        send(12'h7FF, 2'b01, ex(0,7,15,0,1),  "bp6");
        send(12'hFD6, 2'b10, ex(1,2,10,0,1),  "bp7");
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_out_count", n_out - out_base, 8);

    // Reset with three beats in flight.
    send(12'h07D, 2'b00, ex(0,4,8,0,1),  "rs0");
    send(12'h02A, 2'b00, ex(0,2,11,0,1), "rs1");
    send(12'h7FF, 2'b00, ex(0,7,15,1,1), "rs2");
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outs", w_obs, 0);
    check("midrst_sat_count", sat_count, 0);
    exp_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(12'h02A, 2'b10, ex(0,2,10,0,1), "postrst_beat");
    check_latency("postrst_latency");
    drain("postrst");
    repeat (5) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
